// File: rtl/mux_scan_pkg.sv
// Shared definitions for the mux scan sequencer: FSM state encoding and
// default sizing for the channel count and dwell-count width.
package mux_scan_pkg;

    localparam int N_DEFAULT       = 4;
    localparam int DWELL_W_DEFAULT = 4;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SCAN = 1'b1
    } state_t;

endpackage

// File: rtl/mux_dwell_timer.sv
// Reloadable down-counter that times how long each mux channel is held.
// load has priority over counting; zero flags the last cycle of a dwell.
module mux_dwell_timer #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic         en,
    input  logic [W-1:0] reload,
    output logic         zero
);

    logic [W-1:0] dcnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dcnt <= '0;
        end else if (load) begin
            dcnt <= reload;
        end else if (en && (dcnt != '0)) begin
            dcnt <= dcnt - 1'b1;
        end
    end

    assign zero = (dcnt == '0);

endmodule

// File: rtl/mux_scan_sequencer.sv
// Steps an N:1 mux through every channel with a programmable dwell, packs one
// sample per channel into a frame word and offers it downstream.
module mux_scan_sequencer
    import mux_scan_pkg::*;
#(
    parameter  int N       = N_DEFAULT,
    parameter  int DWELL_W = DWELL_W_DEFAULT,
    localparam int SEL_W   = $clog2(N)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               stop,
    input  logic [DWELL_W-1:0] dwell,
    input  logic               mux_o,
    output logic               mux_en,
    output logic [SEL_W-1:0]   mux_sel,
    output logic [N-1:0]       frame,
    output logic               frame_valid,
    input  logic               frame_ready,
    output logic               busy,
    output logic               overrun
);

    state_t             state;
    logic [DWELL_W-1:0] dwell_q;
    logic               stop_pending;
    logic [N-2:0]       shadow;
    logic               dwell_zero;

    logic start_go;
    logic step;
    logic frame_done;
    logic handshake;

    // Handshake: a frame transfers on any clk edge where frame_valid && frame_ready;
    // frame_valid never drops and frame never changes until that transfer happens.
    assign start_go   = (state == ST_IDLE) && start;
    assign step       = (state == ST_SCAN) && dwell_zero;
    assign frame_done = step && (mux_sel == SEL_W'(N - 1));
    assign handshake  = frame_valid && frame_ready;
    assign busy       = (state == ST_SCAN);

    mux_dwell_timer #(
        .W (DWELL_W)
    ) u_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (start_go || step),
        .en     (state == ST_SCAN),
        .reload (start_go ? dwell : dwell_q),
        .zero   (dwell_zero)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            dwell_q      <= '0;
            stop_pending <= 1'b0;
            shadow       <= '0;
            mux_en       <= 1'b0;
            mux_sel      <= '0;
            frame        <= '0;
            frame_valid  <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        dwell_q      <= dwell;
                        mux_sel      <= '0;
                        mux_en       <= 1'b1;
                        overrun      <= 1'b0;
                        stop_pending <= stop;
                        state        <= ST_SCAN;
                    end
                end
                ST_SCAN: begin
                    if (stop) begin
                        stop_pending <= 1'b1;
                    end
                    if (dwell_zero) begin
                        for (int k = 0; k < N - 1; k++) begin
                            if (mux_sel == SEL_W'(k)) begin
                                shadow[k] <= mux_o;
                            end
                        end
                        if (mux_sel != SEL_W'(N - 1)) begin
                            mux_sel <= mux_sel + 1'b1;
                        end else begin
                            mux_sel <= '0;
                            // A stop seen on this very edge still buys one more frame.
                            if (stop_pending) begin
                                stop_pending <= 1'b0;
                                mux_en       <= 1'b0;
                                state        <= ST_IDLE;
                            end
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase

            // The last channel's sample is taken straight from mux_o.
            if (frame_done) begin
                if (!frame_valid || frame_ready) begin
                    frame       <= {mux_o, shadow};
                    frame_valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (handshake) begin
                frame_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mux_scan_sequencer.sv
// Bench for mux_scan_sequencer driving a behavioural 4:1 mux; frames are
// scoreboarded against a timing/content model derived from dwell and stop time.
module tb_mux_scan_sequencer;
    localparam int N = 4;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic         stop;
    logic [3:0]   dwell;
    logic         mux_o;
    logic         mux_en;
    logic [1:0]   mux_sel;
    logic [N-1:0] frame;
    logic         frame_valid;
    logic         frame_ready;
    logic         busy;
    logic         overrun;
    logic [3:0]   d_bits;

    int checks = 0;
    int passes = 0;
    int cyc    = 0;

    logic [N-1:0] exp_q[$];
    int           exp_t_q[$];

    bit   track = 0;
    int   trk_s, trk_d, trk_e;
    int   rise_cyc = 0;
    logic prev_valid = 0;
    logic prev_hs = 0;
    logic [N-1:0] prev_frame = '0;

    mux_scan_sequencer #(.N(N), .DWELL_W(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .stop        (stop),
        .dwell       (dwell),
        .mux_o       (mux_o),
        .mux_en      (mux_en),
        .mux_sel     (mux_sel),
        .frame       (frame),
        .frame_valid (frame_valid),
        .frame_ready (frame_ready),
        .busy        (busy),
        .overrun     (overrun)
    );

    // mux_Nx1 with data inputs d_bits
    assign mux_o = mux_en ? d_bits[mux_sel] : 1'b0;

    // clock / cycle counter
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // monitor: pops the scoreboard on each handshake, checks hold stability and scan order
    always @(negedge clk) begin
        #1;
        if (rst_n) begin
            if (frame_valid && !prev_valid) rise_cyc = cyc;
            if (prev_valid && !prev_hs && frame_valid)
                check("frame_stable", 32'(frame), 32'(prev_frame));
            if (frame_valid && frame_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    $display("FAIL unexpected_frame: got %0h, required no frame (cycle %0d)", frame, cyc);
                end else begin
                    logic [N-1:0] e;
                    int t;
                    e = exp_q.pop_front();
                    t = exp_t_q.pop_front();
                    check("frame_data", 32'(frame), 32'(e));
                    check("frame_latency", 32'(rise_cyc), 32'(t));
                end
            end
            if (track && cyc >= trk_s && cyc < trk_e) begin
                check("scan_sel", 32'(mux_sel), 32'(((cyc - trk_s) / (trk_d + 1)) % N));
                check("scan_en", 32'(mux_en), 32'd1);
                check("scan_busy", 32'(busy), 32'd1);
            end
            prev_valid = frame_valid;
            prev_hs    = frame_valid && frame_ready;
            prev_frame = frame;
        end else begin
            prev_valid = 1'b0;
            prev_hs    = 1'b0;
        end
    end

    // One scan run: frames complete every N*(D+1) cycles after the start edge;
    // the frame in which stop is sampled is the last one.
    task automatic run_scan(input int d, input logic [3:0] dv, input bit single,
                            input int stop_delay, input bit rdy);
        int s, len, stop_edge, k_frames, n;
        @(negedge clk);
        d_bits = dv; frame_ready = rdy; dwell = 4'(d); start = 1'b1; stop = single;
        @(posedge clk);
        #1;
        s = cyc;
        len = N * (d + 1);
        stop_edge = single ? s : s + stop_delay + 1;
        k_frames = (stop_edge - s) / len + 1;
        for (int k = 1; k <= k_frames; k++) begin
            if (rdy || k == 1) begin
                exp_q.push_back(dv);
                exp_t_q.push_back(s + k * len);
            end
        end
        trk_s = s; trk_d = d; trk_e = s + k_frames * len; track = 1;
        @(negedge clk);
        start = 1'b0; stop = 1'b0;
        if (!single) begin
            while (cyc < s + stop_delay) @(negedge clk);
            stop = 1'b1;
            @(negedge clk);
            stop = 1'b0;
        end
        n = 0;
        while (busy && n < k_frames * len + 20) begin
            @(negedge clk);
            n++;
        end
        check("busy_idle", 32'(busy), 32'd0);
        check("scan_end_cycle", 32'(cyc), 32'(trk_e));
        check("idle_mux_en", 32'(mux_en), 32'd0);
        check("idle_mux_sel", 32'(mux_sel), 32'd0);
        check("overrun_end", 32'(overrun), 32'(!rdy && k_frames >= 2));
        track = 0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int n, d;
        rst_n = 1'b0; start = 1'b0; stop = 1'b0; dwell = '0;
        frame_ready = 1'b0; d_bits = 4'b1001;

        // reset state
        repeat (3) @(negedge clk);
        check("rst_mux_en", 32'(mux_en), 32'd0);
        check("rst_mux_sel", 32'(mux_sel), 32'd0);
        check("rst_frame", 32'(frame), 32'd0);
        check("rst_frame_valid", 32'(frame_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        check("idle_after_rst", 32'(busy), 32'd0);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        @(negedge clk);
        check("stop_in_idle", 32'(busy), 32'd0);

        // single shot, dwell 0
        run_scan(0, 4'b1001, 1'b1, 0, 1'b1);
        // continuous, dwell 3, three frames
        run_scan(3, 4'b1001, 1'b0, 2 * 16 + 5, 1'b1);

        // backpressure: first frame held, second completion overruns
        fork
            run_scan(3, 4'b1001, 1'b0, 2 * 16 + 5, 1'b0);
            begin
                wait (track);
                while (cyc < trk_s + 31) @(negedge clk);
                check("bp_overrun_before", 32'(overrun), 32'd0);
                check("bp_valid_held", 32'(frame_valid), 32'd1);
                check("bp_frame_held", 32'(frame), 32'b1001);
                @(negedge clk);
                check("bp_overrun_at_2nd", 32'(overrun), 32'd1);
                check("bp_frame_kept", 32'(frame), 32'b1001);
            end
        join
        @(negedge clk);
        frame_ready = 1'b1;
        repeat (2) @(negedge clk);
        check("bp_drained", 32'(frame_valid), 32'd0);
        check("bp_overrun_sticky", 32'(overrun), 32'd1);
        // a fresh start clears overrun
        run_scan(0, 4'b0110, 1'b1, 0, 1'b1);

        // stop while mux_sel==1: one frame only
        d = $urandom_range(1, 3);
        run_scan(d, 4'($urandom_range(0, 15)), 1'b0, d + 1, 1'b1);

        // randomized runs
        for (int r = 0; r < 8; r++) begin
            d = $urandom_range(0, 5);
            run_scan(d, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                     $urandom_range(0, 3 * N * (d + 1) - 2), 1'b1);
        end

        // asynchronous reset mid-scan at mux_sel==2
        @(negedge clk);
        d_bits = 4'($urandom_range(0, 15)); dwell = 4'($urandom_range(1, 3));
        frame_ready = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (mux_sel != 2'd2 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("reach_sel2", 32'(mux_sel), 32'd2);
        #2 rst_n = 1'b0;
        #1;
        check("arst_mux_en", 32'(mux_en), 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_valid", 32'(frame_valid), 32'd0);
        check("arst_mux_sel", 32'(mux_sel), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        check("arst_stays_idle", 32'(busy), 32'd0);
        check("arst_no_frame", 32'(frame_valid), 32'd0);

        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
